// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the fetch/data memory
//                arbiter: FSM state encoding, owner encoding, abort read
//                data and the fixed word-size code used for fetches.
//  Ports       : (package, none)
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   // Identity of the last granted requester (alternation bookkeeping)
   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   // Read data returned to the owner when an access is aborted by timeout
   localparam logic [31:0] c_ABORT_RDATA  = 32'hDEADBEEF;

   // Fetches are always full-word accesses
   localparam logic [2:0]  c_FETCH_FUNCT3 = 3'b010;

   // Width of the BUSY-cycle counter (TIMEOUT is limited to 1..255)
   localparam int unsigned c_CNT_W        = 8;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of all request/response and shared memory port
//                signals around the arbiter.
//  Modports    : master - arbiter view (drives grants, responses, m_* port)
//                slave  - environment view (fetch/data masters and memory)
//  Signals     : i_*  instruction-fetch request/response
//                d_*  data load/store request/response
//                m_*  shared memory port
//                err  timeout indication, pulses with the owner's rvalid
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Instruction-fetch side
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   // Data side
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [2:0]        d_funct3;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   // Shared memory port
   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [2:0]        m_funct3;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   // Timeout flag
   logic              err;

   modport master (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata, d_funct3,
      input  m_ack, m_rdata,
      output i_gnt, i_rvalid, i_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_addr, m_wdata, m_funct3,
      output err
   );

   modport slave (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata, d_funct3,
      output m_ack, m_rdata,
      input  i_gnt, i_rvalid, i_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_addr, m_wdata, m_funct3,
      input  err
   );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_timer
//  Description : Counts BUSY cycles of the current memory access and flags
//                the cycle in which the TIMEOUT-th BUSY cycle is reached.
//  Ports       : clk       - clock
//                rst       - asynchronous active-high reset
//                i_clear   - restart the count (access granted)
//                i_enable  - an access is outstanding (BUSY state)
//                o_expired - current cycle is the TIMEOUT-th BUSY cycle
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // r_cnt holds (BUSY cycles elapsed - 1) during BUSY, so the compare
   // against TIMEOUT-1 fires in the TIMEOUT-th BUSY cycle itself.
   assign o_expired = i_enable && (r_cnt == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : mem_arb_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master arbiter sharing one memory port between an
//                instruction-fetch master and a data load/store master.
//                One outstanding access at a time; contention alternates
//                starting with the data master; a stalled access is aborted
//                after TIMEOUT BUSY cycles.
//  Ports       : clk - clock, rising edge
//                rst - asynchronous active-high reset
//                bus - mem_arbiter_if.master (fetch, data and memory sides)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   localparam logic [DATA_W-1:0] c_ABORT_WORD = DATA_W'(c_ABORT_RDATA);

   state_t             r_state;
   state_t             w_state_nxt;
   owner_t             r_last;

   logic               w_i_gnt;
   logic               w_d_gnt;
   logic               w_ack_done;
   logic               w_abort;
   logic               w_busy;
   logic               w_tmr_expired;

   logic               r_m_req;
   logic               r_m_we;
   logic [ADDR_W-1:0]  r_m_addr;
   logic [DATA_W-1:0]  r_m_wdata;
   logic [2:0]         r_m_funct3;
   logic               r_i_rvalid;
   logic [DATA_W-1:0]  r_i_rdata;
   logic               r_d_rvalid;
   logic [DATA_W-1:0]  r_d_rdata;
   logic               r_err;

   assign w_busy = (r_state != S_IDLE);

   // ------------------------------------------------------------------------
   // Timeout counter: restarted on every grant, runs while BUSY
   // ------------------------------------------------------------------------
   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_i_gnt | w_d_gnt),
      .i_enable  (w_busy),
      .o_expired (w_tmr_expired)
   );

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and combinational grant / completion decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_i_gnt     = 1'b0;
      w_d_gnt     = 1'b0;
      w_ack_done  = 1'b0;
      w_abort     = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Grants are gated by rst so every output reads 0 during reset
            if (!rst) begin
               if (bus.i_req && bus.d_req) begin
                  if (r_last == OWN_DATA) begin
                     w_i_gnt = 1'b1;
                  end else begin
                     w_d_gnt = 1'b1;
                  end
               end else if (bus.i_req) begin
                  w_i_gnt = 1'b1;
               end else if (bus.d_req) begin
                  w_d_gnt = 1'b1;
               end
            end
            if (w_i_gnt) begin
               w_state_nxt = S_BUSY_I;
            end else if (w_d_gnt) begin
               w_state_nxt = S_BUSY_D;
            end
         end

         S_BUSY_I, S_BUSY_D: begin
            // An acknowledge in the expiry cycle still completes normally
            if (bus.m_ack) begin
               w_ack_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_tmr_expired) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Memory port, response and alternation registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last     <= OWN_FETCH;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_m_funct3 <= '0;
         r_i_rvalid <= 1'b0;
         r_i_rdata  <= '0;
         r_d_rvalid <= 1'b0;
         r_d_rdata  <= '0;
         r_err      <= 1'b0;
      end else begin
         // Response strobes are single-cycle pulses
         r_i_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_err      <= 1'b0;

         if (w_i_gnt) begin
            r_last     <= OWN_FETCH;
            r_m_req    <= 1'b1;
            r_m_we     <= 1'b0;
            r_m_addr   <= bus.i_addr;
            r_m_wdata  <= '0;
            r_m_funct3 <= c_FETCH_FUNCT3;
         end else if (w_d_gnt) begin
            r_last     <= OWN_DATA;
            r_m_req    <= 1'b1;
            r_m_we     <= bus.d_we;
            r_m_addr   <= bus.d_addr;
            r_m_wdata  <= bus.d_wdata;
            r_m_funct3 <= bus.d_funct3;
         end else if (w_ack_done || w_abort) begin
            // Address/data are left as-is; only the request drops
            r_m_req    <= 1'b0;
         end

         if (w_ack_done || w_abort) begin
            r_err <= w_abort;
            if (r_state == S_BUSY_I) begin
               r_i_rvalid <= 1'b1;
               r_i_rdata  <= w_abort ? c_ABORT_WORD : bus.m_rdata;
            end else begin
               r_d_rvalid <= 1'b1;
               if (w_abort) begin
                  r_d_rdata <= c_ABORT_WORD;
               end else if (r_m_we) begin
                  r_d_rdata <= '0;
               end else begin
                  r_d_rdata <= bus.m_rdata;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.i_gnt    = w_i_gnt;
   assign bus.d_gnt    = w_d_gnt;
   assign bus.i_rvalid = r_i_rvalid;
   assign bus.i_rdata  = r_i_rdata;
   assign bus.d_rvalid = r_d_rvalid;
   assign bus.d_rdata  = r_d_rdata;
   assign bus.m_req    = r_m_req;
   assign bus.m_we     = r_m_we;
   assign bus.m_addr   = r_m_addr;
   assign bus.m_wdata  = r_m_wdata;
   assign bus.m_funct3 = r_m_funct3;
   assign bus.err      = r_err;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A per-cycle vector
//                table covers fetch, store, alternation, dropped requests and
//                stray acknowledges; hand-written sequences cover timeout
//                abort, acknowledge on the expiry cycle and reset in BUSY.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int TB_TIMEOUT = 5;
   localparam int N_VEC      = 20;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // One record per clock cycle: inputs applied in that cycle and the
   // outputs expected in that same cycle.
   typedef struct {
      logic        ir;
      logic        dr;
      logic        dwe;
      logic        ack;
      logic [31:0] mrd;
      logic        eig;
      logic        edg;
      logic        emreq;
      logic        emwe;
      logic [31:0] emaddr;
      logic [2:0]  emf3;
      logic        eirv;
      logic        edrv;
      logic        eerr;
      logic [31:0] erd;
   } vec_t;

   vec_t vecs [N_VEC];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ------------------------------------------------------------ table
      vecs[0]  = '{H,H,H,L,32'h0,        L,H,L,L,32'h0,  3'b000,L,L,L,32'h0};
      vecs[1]  = '{H,L,H,H,32'h12345678, L,L,H,H,32'h100,3'b101,L,L,L,32'h0};
      vecs[2]  = '{H,L,L,L,32'h0,        H,L,L,L,32'h0,  3'b000,L,H,L,32'h0};
      vecs[3]  = '{L,L,L,H,32'h00500093, L,L,H,L,32'h10, 3'b010,L,L,L,32'h0};
      vecs[4]  = '{L,L,L,L,32'h0,        L,L,L,L,32'h0,  3'b000,H,L,L,32'h00500093};
      vecs[5]  = '{H,H,L,L,32'h0,        L,H,L,L,32'h0,  3'b000,L,L,L,32'h0};
      vecs[6]  = '{H,H,L,H,32'hA0000001, L,L,H,L,32'h100,3'b101,L,L,L,32'h0};
      vecs[7]  = '{H,H,L,L,32'h0,        H,L,L,L,32'h0,  3'b000,L,H,L,32'hA0000001};
      vecs[8]  = '{H,H,L,H,32'hA0000002, L,L,H,L,32'h10, 3'b010,L,L,L,32'h0};
      vecs[9]  = '{H,H,L,L,32'h0,        L,H,L,L,32'h0,  3'b000,H,L,L,32'hA0000002};
      vecs[10] = '{H,H,L,H,32'hA0000003, L,L,H,L,32'h100,3'b101,L,L,L,32'h0};
      vecs[11] = '{H,H,L,L,32'h0,        H,L,L,L,32'h0,  3'b000,L,H,L,32'hA0000003};
      vecs[12] = '{H,H,L,H,32'hA0000004, L,L,H,L,32'h10, 3'b010,L,L,L,32'h0};
      vecs[13] = '{H,H,L,L,32'h0,        L,H,L,L,32'h0,  3'b000,H,L,L,32'hA0000004};
      vecs[14] = '{H,H,L,H,32'hA0000005, L,L,H,L,32'h100,3'b101,L,L,L,32'h0};
      vecs[15] = '{H,H,L,L,32'h0,        H,L,L,L,32'h0,  3'b000,L,H,L,32'hA0000005};
      vecs[16] = '{L,H,L,L,32'h0,        L,L,H,L,32'h10, 3'b010,L,L,L,32'h0};
      vecs[17] = '{L,L,L,H,32'hA0000006, L,L,H,L,32'h10, 3'b010,L,L,L,32'h0};
      vecs[18] = '{L,L,L,H,32'h0,        L,L,L,L,32'h0,  3'b000,H,L,L,32'hA0000006};
      vecs[19] = '{L,L,L,L,32'h0,        L,L,L,L,32'h0,  3'b000,L,L,L,32'h0};

      // ------------------------------------------------------------ reset
      rst          = 1'b1;
      bus.i_req    = 1'b1;
      bus.i_addr   = 32'h10;
      bus.d_req    = 1'b1;
      bus.d_we     = 1'b1;
      bus.d_addr   = 32'h100;
      bus.d_wdata  = 32'hCAFE;
      bus.d_funct3 = 3'b101;
      bus.m_ack    = 1'b0;
      bus.m_rdata  = 32'h0;
      sample();
      chk("reset i_gnt",    32'(bus.i_gnt),    32'h0);
      chk("reset d_gnt",    32'(bus.d_gnt),    32'h0);
      chk("reset m_req",    32'(bus.m_req),    32'h0);
      chk("reset m_addr",   bus.m_addr,        32'h0);
      chk("reset i_rvalid", 32'(bus.i_rvalid), 32'h0);
      chk("reset d_rvalid", 32'(bus.d_rvalid), 32'h0);
      chk("reset err",      32'(bus.err),      32'h0);
      step();
      rst       = 1'b0;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;

      // ------------------------------------------------------------ vectors
      for (int k = 0; k < N_VEC; k++) begin
         step();
         bus.i_req   = vecs[k].ir;
         bus.d_req   = vecs[k].dr;
         bus.d_we    = vecs[k].dwe;
         bus.m_ack   = vecs[k].ack;
         bus.m_rdata = vecs[k].mrd;
         sample();
         chk($sformatf("v%0d i_gnt", k),    32'(bus.i_gnt),    32'(vecs[k].eig));
         chk($sformatf("v%0d d_gnt", k),    32'(bus.d_gnt),    32'(vecs[k].edg));
         chk($sformatf("v%0d m_req", k),    32'(bus.m_req),    32'(vecs[k].emreq));
         chk($sformatf("v%0d i_rvalid", k), 32'(bus.i_rvalid), 32'(vecs[k].eirv));
         chk($sformatf("v%0d d_rvalid", k), 32'(bus.d_rvalid), 32'(vecs[k].edrv));
         chk($sformatf("v%0d err", k),      32'(bus.err),      32'(vecs[k].eerr));
         if (vecs[k].emreq) begin
            chk($sformatf("v%0d m_we", k),     32'(bus.m_we),     32'(vecs[k].emwe));
            chk($sformatf("v%0d m_addr", k),   bus.m_addr,        vecs[k].emaddr);
            chk($sformatf("v%0d m_funct3", k), 32'(bus.m_funct3), 32'(vecs[k].emf3));
            if (vecs[k].emwe)
               chk($sformatf("v%0d m_wdata", k), bus.m_wdata, 32'hCAFE);
         end
         if (vecs[k].eirv)
            chk($sformatf("v%0d i_rdata", k), bus.i_rdata, vecs[k].erd);
         if (vecs[k].edrv)
            chk($sformatf("v%0d d_rdata", k), bus.d_rdata, vecs[k].erd);
      end

      // ------------------------------------------------ load timeout abort
      step();
      bus.d_req = 1'b1;
      bus.d_we  = 1'b0;
      bus.m_ack = 1'b0;
      sample();
      chk("to d_gnt", 32'(bus.d_gnt), 32'h1);
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
         step();
         bus.d_req = 1'b0;
         sample();
         chk($sformatf("to busy%0d m_req", k),    32'(bus.m_req),    32'h1);
         chk($sformatf("to busy%0d d_rvalid", k), 32'(bus.d_rvalid), 32'h0);
         chk($sformatf("to busy%0d err", k),      32'(bus.err),      32'h0);
      end
      step();
      bus.i_req   = 1'b1;
      bus.m_rdata = 32'h0BADF00D;
      sample();
      chk("to d_rvalid",      32'(bus.d_rvalid), 32'h1);
      chk("to err",           32'(bus.err),      32'h1);
      chk("to d_rdata",       bus.d_rdata,       32'hDEADBEEF);
      chk("to m_req cleared", 32'(bus.m_req),    32'h0);
      chk("to idle i_gnt",    32'(bus.i_gnt),    32'h1);

      // ------------------------------------- ack on the expiry cycle wins
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
         step();
         bus.i_req = 1'b0;
         bus.m_ack = (k == TB_TIMEOUT);
         sample();
         chk($sformatf("ax busy%0d i_rvalid", k), 32'(bus.i_rvalid), 32'h0);
         chk($sformatf("ax busy%0d err", k),      32'(bus.err),      32'h0);
      end
      step();
      bus.m_ack = 1'b0;
      sample();
      chk("ax i_rvalid", 32'(bus.i_rvalid), 32'h1);
      chk("ax i_rdata",  bus.i_rdata,       32'h0BADF00D);
      chk("ax err",      32'(bus.err),      32'h0);
      chk("ax m_req",    32'(bus.m_req),    32'h0);

      // --------------------------------------------- reset during BUSY_I
      step();
      bus.i_req = 1'b1;
      sample();
      chk("rb i_gnt", 32'(bus.i_gnt), 32'h1);
      step();
      bus.i_req = 1'b0;
      sample();
      chk("rb busy m_req", 32'(bus.m_req), 32'h1);
      step();
      #2;
      rst       = 1'b1;
      bus.i_req = 1'b1;
      #1;
      chk("rb async m_req",  32'(bus.m_req),  32'h0);
      chk("rb async m_addr", bus.m_addr,      32'h0);
      chk("rb async i_gnt",  32'(bus.i_gnt),  32'h0);
      chk("rb async i_rdata", bus.i_rdata,    32'h0);
      step();
      step();
      rst       = 1'b0;
      bus.i_req = 1'b0;
      bus.m_ack = 1'b1;
      bus.m_rdata = 32'h55AA55AA;
      sample();
      chk("rb post m_req", 32'(bus.m_req), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         bus.m_ack = 1'b0;
         sample();
         chk($sformatf("rb stray%0d i_rvalid", k), 32'(bus.i_rvalid), 32'h0);
         chk($sformatf("rb stray%0d d_rvalid", k), 32'(bus.d_rvalid), 32'h0);
         chk($sformatf("rb stray%0d m_req", k),    32'(bus.m_req),    32'h0);
         chk($sformatf("rb stray%0d err", k),      32'(bus.err),      32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
